mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported memory between the instruction-fetch port and the data (load/store) port of the pipeline. Each requester uses a level activate / one-cycle done handshake. The arbiter grants one requester at a time, latches its request, and drives the memory until `mem_done`. It then routes the read data and done pulse back to the granted requester only.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width; `DATA_WIDTH/8` write strobes

- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-low reset; asserts immediately and is released synchronously to `clk`
- `i_addr` in ADDR_WIDTH: fetch address
- `i_activate` in 1: fetch request, held until `i_done`
- `i_data` out DATA_WIDTH: fetch read data, valid with `i_done`
- `i_done` out 1: one-cycle fetch completion
- `d_addr` in ADDR_WIDTH: data address
- `d_activate` in 1: data request, held until `d_done`
- `d_write` in 1: 1 = store, 0 = load
- `d_wdata` in DATA_WIDTH: store data
- `d_wstrb` in DATA_WIDTH/8: store byte enables
- `d_data` out DATA_WIDTH: load data, valid with `d_done`
- `d_done` out 1: one-cycle data completion
- `mem_addr` out ADDR_WIDTH: latched address
- `mem_activate` out 1: memory request, held until `mem_done`
- `mem_write`, `mem_wdata`, `mem_wstrb` out 1/DATA_WIDTH/DATA_WIDTH/8: latched store fields
- `mem_rdata` in DATA_WIDTH: memory read data
- `mem_done` in 1: one-cycle memory completion

## Operation
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE:
  - Samples `i_activate`/`d_activate`. If either is high, it picks a winner, latches the winner's addr/write/wdata/wstrb, and moves to BUSY_I or BUSY_D on the edge.
  - Both requesters high at once: priority per Configuration.
- BUSY_x:
  - `mem_activate`=1, and `mem_*` come from latched registers. Later requester input changes are ignored.
  - On `mem_done`, the arbiter returns to IDLE. The next grant is decided from IDLE, never on the done edge. This stops a requester that is still holding activate from receiving a duplicate transaction.
- Return path:
  - `x_done` = `mem_done` && state==BUSY_x && `x_activate` && `!abort_x`, all combinational.
  - `i_data`/`d_data` = `mem_rdata`, unconditionally.
  - The non-granted requester's done stays 0.
- Abort:
  - If the granted requester drops activate while BUSY, the sticky `abort_x` flag sets.
  - The memory transaction still completes (a store is still written). Its done is suppressed, and `abort_x` clears on leaving BUSY.
- `mem_write` is forced 0 for fetch grants.
- No address arithmetic; addresses pass through unchanged.
- Reset values:
  - state=IDLE, `mem_activate`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
  - `i_done`=`d_done`=0, and all abort flags=0.
  - RR pointer favours data.
- Reset mid-transaction: the arbiter drops `mem_activate` immediately. The memory must tolerate an abandoned request.

## Timing
- Grant latency: request high in IDLE at cycle N gives `mem_activate` high from N+1.
- Completion: `mem_done` at cycle M gives `x_done` in the same cycle M (zero added latency), and IDLE at M+1.
- Minimum turnaround is 1 idle cycle between transactions. Back-to-back throughput is one transaction per (memory latency + 1) cycles.
- `mem_done` while IDLE is ignored and is not an error.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant the requester not served last.
  - A 1-bit last-grant register updates on each grant.
- Undefined: fixed priority, data port always wins. A continuous data stream may starve fetch.

## Structure
- `mem_pkg`: `ADDR_WIDTH`/`DATA_WIDTH` constants, `mem_req_t` struct (addr, write, wdata, wstrb), `arb_state_t` enum (IDLE, BUSY_I, BUSY_D).
- One sub-module, `mem_arb_pick`: combinational winner select from two requests plus last-grant bit, with a fixed/RR variant under the macro.

## Test plan
- Single fetch: `i_addr`=0x100 held, memory returns 0xDEADBEEF after 3 cycles. Expect `mem_activate` on cycle 1, `i_done`+`i_data`=0xDEADBEEF on the `mem_done` cycle, IDLE next cycle, no duplicate request.
- Store: `d_addr`=0x2000, wdata=0x12345678, wstrb=0b0011. Expect `mem_write`=1, fields latched, and unchanged after `d_wdata` is changed mid-transaction.
- Simultaneous requests held for 4 transactions: RR build gives I/D alternation (D first after reset); fixed build gives D,D,D,D with `i_done` never asserted.
- Abort: drop `i_activate` in the cycle after grant. Expect `mem_activate` held until `mem_done`, `i_done`=0, then a pending `d_activate` granted next.
- Async reset: pull `rst` low mid-BUSY_D between edges. Expect `mem_activate`/`d_done` 0 immediately; after release, state IDLE and a new request granted normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: widths and shared types for the instruction/data memory arbiter.
package mem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // One memory transaction as seen by the single memory port.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } mem_req_t;

    // Arbiter FSM: idle, or busy serving the fetch (I) or data (D) port.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the fetch and data
// requests. Build option MEM_ARBITER_ROUND_ROBIN_EN selects round robin on a
// tie (the port not served last wins); without it the data port always wins.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant_d,
    output logic gnt_i,
    output logic gnt_d
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On a tie, alternate away from whichever port won the previous grant.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (i_req && d_req) begin
            gnt_d = ~last_grant_d;
            gnt_i = last_grant_d;
        end else begin
            gnt_i = i_req;
            gnt_d = d_req;
        end
    end
`else
    // Fixed priority has no history; the last-grant input is not needed.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant_d;

    // Fixed priority: data wins any tie, fetch only when data is quiet.
    always_comb begin
        gnt_d = d_req;
        gnt_i = i_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// and data ports. A grant is only decided from IDLE, the winning request is
// latched for the whole transaction, and the completion is routed back to the
// granted port only. Build option MEM_ARBITER_ROUND_ROBIN_EN enables round
// robin arbitration; the default build uses fixed data-first priority.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    // instruction-fetch port
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_activate,
    output logic [DATA_WIDTH-1:0]   i_data,
    output logic                    i_done,
    // data (load/store) port
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_activate,
    input  logic                    d_write,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_done,
    // shared memory port
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_activate,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_done
);

    localparam int SW = DATA_WIDTH / 8;

    arb_state_t              state_r;
    logic                    mem_activate_r;
    logic                    mem_write_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [SW-1:0]           mem_wstrb_r;
    logic                    abort_i_r;
    logic                    abort_d_r;
    logic                    gnt_i_s;
    logic                    gnt_d_s;
    logic                    last_grant_s;

    mem_arb_pick u_pick (
        .i_req        (i_activate),
        .d_req        (d_activate),
        .last_grant_d (last_grant_s),
        .gnt_i        (gnt_i_s),
        .gnt_d        (gnt_d_s)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_grant_d_r;

    // Remember which port won the latest grant; reset value 0 lets data win first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_d_r <= 1'b0;
        end else if ((state_r == IDLE) && (gnt_i_s || gnt_d_s)) begin
            last_grant_d_r <= gnt_d_s;
        end else begin
            last_grant_d_r <= last_grant_d_r;
        end
    end

    assign last_grant_s = last_grant_d_r;
`else
    assign last_grant_s = 1'b0;
`endif

    // Arbiter FSM: grant from IDLE, hold latched request until mem_done, track aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            mem_activate_r <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_addr_r     <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r    <= {DATA_WIDTH{1'b0}};
            mem_wstrb_r    <= {SW{1'b0}};
            abort_i_r      <= 1'b0;
            abort_d_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_d_s) begin
                        state_r        <= BUSY_D;
                        mem_activate_r <= 1'b1;
                        mem_addr_r     <= d_addr;
                        mem_write_r    <= d_write;
                        mem_wdata_r    <= d_wdata;
                        mem_wstrb_r    <= d_wstrb;
                    end else if (gnt_i_s) begin
                        // Fetches never write, whatever the store fields hold.
                        state_r        <= BUSY_I;
                        mem_activate_r <= 1'b1;
                        mem_addr_r     <= i_addr;
                        mem_write_r    <= 1'b0;
                        mem_wdata_r    <= {DATA_WIDTH{1'b0}};
                        mem_wstrb_r    <= {SW{1'b0}};
                    end else begin
                        state_r        <= IDLE;
                        mem_activate_r <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (mem_done) begin
                        state_r        <= IDLE;
                        mem_activate_r <= 1'b0;
                        abort_i_r      <= 1'b0;
                    end else if (!i_activate) begin
                        abort_i_r      <= 1'b1;
                    end else begin
                        abort_i_r      <= abort_i_r;
                    end
                end
                BUSY_D: begin
                    if (mem_done) begin
                        state_r        <= IDLE;
                        mem_activate_r <= 1'b0;
                        abort_d_r      <= 1'b0;
                    end else if (!d_activate) begin
                        abort_d_r      <= 1'b1;
                    end else begin
                        abort_d_r      <= abort_d_r;
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    mem_activate_r <= 1'b0;
                    abort_i_r      <= 1'b0;
                    abort_d_r      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_activate = mem_activate_r;
    assign mem_write    = mem_write_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_wstrb    = mem_wstrb_r;

    // Completion is passed through in the mem_done cycle, only to the granted,
    // still-requesting, non-aborted port.
    assign i_done = mem_done & (state_r == BUSY_I) & i_activate & ~abort_i_r;
    assign d_done = mem_done & (state_r == BUSY_D) & d_activate & ~abort_d_r;
    assign i_data = mem_rdata;
    assign d_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_activate;
    logic [31:0] i_data;
    logic        i_done;
    logic [31:0] d_addr;
    logic        d_activate;
    logic        d_write;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_data;
    logic        d_done;
    logic [31:0] mem_addr;
    logic        mem_activate;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int checks = 0;
    int passed = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_activate(i_activate), .i_data(i_data), .i_done(i_done),
        .d_addr(d_addr), .d_activate(d_activate), .d_write(d_write),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_data(d_data), .d_done(d_done),
        .mem_addr(mem_addr), .mem_activate(mem_activate), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_done(mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_addr = 32'd0; i_activate = 1'b0;
        d_addr = 32'd0; d_activate = 1'b0; d_write = 1'b0;
        d_wdata = 32'd0; d_wstrb = 4'd0;
        mem_rdata = 32'd0; mem_done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mem_activate !== 1'b0) $display("FAIL reset_activate: got %0b want 0", mem_activate); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL reset_write: got %0b want 0", mem_write); else passed++;
        checks++; if (mem_addr !== 32'd0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passed++;
        checks++; if ({mem_wdata, mem_wstrb} !== 36'd0) $display("FAIL reset_wfields: got %h/%h want 0", mem_wdata, mem_wstrb); else passed++;
        mem_done = 1'b1; i_activate = 1'b1; d_activate = 1'b1;
        #1;
        checks++; if ({i_done, d_done} !== 2'b00) $display("FAIL reset_done: got %b want 00", {i_done, d_done}); else passed++;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        // mem_done while idle must be ignored
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
        checks++; if (mem_activate !== 1'b0) $display("FAIL idle_done_ignored: activate %0b want 0", mem_activate); else passed++;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_addr = 32'h100; i_activate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_activate !== 1'b1) $display("FAIL fetch_grant: activate %0b want 1", mem_activate); else passed++;
        checks++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr: got %h want 100", mem_addr); else passed++;
        checks++; if (mem_write !== 1'b0) $display("FAIL fetch_write: got %0b want 0", mem_write); else passed++;
        repeat (2) @(negedge clk);
        checks++; if (mem_activate !== 1'b1) $display("FAIL fetch_hold: activate %0b want 1", mem_activate); else passed++;
        mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (i_done !== 1'b1) $display("FAIL fetch_done: got %0b want 1", i_done); else passed++;
        checks++; if (i_data !== 32'hDEADBEEF) $display("FAIL fetch_data: got %h want deadbeef", i_data); else passed++;
        checks++; if (d_done !== 1'b0) $display("FAIL fetch_no_d_done: got %0b want 0", d_done); else passed++;
        @(posedge clk); #1;
        mem_done = 1'b0; i_activate = 1'b0;
        checks++; if (mem_activate !== 1'b0) $display("FAIL fetch_idle_after: activate %0b want 0", mem_activate); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (mem_activate !== 1'b0) $display("FAIL fetch_no_dup: activate %0b want 0 (cycle %0d)", mem_activate, k); else passed++;
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        d_addr = 32'h2000; d_write = 1'b1; d_wdata = 32'h12345678; d_wstrb = 4'b0011; d_activate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_activate !== 1'b1) $display("FAIL store_grant: activate %0b want 1", mem_activate); else passed++;
        checks++; if ({mem_addr, mem_write, mem_wdata, mem_wstrb} !== {32'h2000, 1'b1, 32'h12345678, 4'b0011})
            $display("FAIL store_fields: got %h %0b %h %b want 2000 1 12345678 0011", mem_addr, mem_write, mem_wdata, mem_wstrb); else passed++;
        d_addr = 32'h3000; d_wdata = 32'hFFFFFFFF; d_wstrb = 4'hF; d_write = 1'b0;
        @(negedge clk);
        checks++; if ({mem_addr, mem_write, mem_wdata, mem_wstrb} !== {32'h2000, 1'b1, 32'h12345678, 4'b0011})
            $display("FAIL store_latched: got %h %0b %h %b want 2000 1 12345678 0011", mem_addr, mem_write, mem_wdata, mem_wstrb); else passed++;
        mem_done = 1'b1; mem_rdata = 32'h0BADF00D;
        #1;
        checks++; if ({d_done, i_done} !== 2'b10) $display("FAIL store_done: d/i %b want 10", {d_done, i_done}); else passed++;
        @(posedge clk); #1;
        mem_done = 1'b0; d_activate = 1'b0;
        checks++; if (mem_activate !== 1'b0) $display("FAIL store_idle_after: activate %0b want 0", mem_activate); else passed++;
    endtask

    task automatic test_simultaneous();
        logic last_d;
        logic exp_d;
        logic got_d;
        apply_reset();
        last_d = 1'b0;
        i_addr = 32'h40; d_addr = 32'h80; d_write = 1'b0;
        i_activate = 1'b1; d_activate = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            exp_d = ~last_d;
`else
            exp_d = 1'b1;
`endif
            last_d = exp_d;
            @(posedge clk);
            @(negedge clk);
            got_d = (mem_addr == 32'h80);
            checks++; if (!mem_activate || got_d !== exp_d) $display("FAIL sim_order[%0d]: act %0b data %0b want data %0b", k, mem_activate, got_d, exp_d); else passed++;
            mem_done = 1'b1; mem_rdata = 32'hA0 + k;
            #1;
            checks++; if ({i_done, d_done} !== {~exp_d, exp_d}) $display("FAIL sim_done[%0d]: i/d %b want %b", k, {i_done, d_done}, {~exp_d, exp_d}); else passed++;
            @(posedge clk); #1;
            mem_done = 1'b0;
        end
        i_activate = 1'b0; d_activate = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        @(negedge clk);
        i_addr = 32'h500; i_activate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (!mem_activate || mem_addr !== 32'h500) $display("FAIL abort_grant: act %0b addr %h want 1 500", mem_activate, mem_addr); else passed++;
        i_activate = 1'b0;
        d_addr = 32'h600; d_write = 1'b0; d_activate = 1'b1;
        @(negedge clk);
        checks++; if (!mem_activate || mem_addr !== 32'h500) $display("FAIL abort_hold: act %0b addr %h want 1 500", mem_activate, mem_addr); else passed++;
        // requester comes back, but the aborted transaction must stay silent
        i_activate = 1'b1;
        mem_done = 1'b1; mem_rdata = 32'h55AA55AA;
        #1;
        checks++; if ({i_done, d_done} !== 2'b00) $display("FAIL abort_suppress: i/d %b want 00", {i_done, d_done}); else passed++;
        @(posedge clk); #1;
        mem_done = 1'b0; i_activate = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (!mem_activate || mem_addr !== 32'h600) $display("FAIL abort_next_d: act %0b addr %h want 1 600", mem_activate, mem_addr); else passed++;
        mem_done = 1'b1;
        #1;
        checks++; if (d_done !== 1'b1) $display("FAIL abort_next_done: got %0b want 1", d_done); else passed++;
        @(posedge clk); #1;
        mem_done = 1'b0; d_activate = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        d_addr = 32'h700; d_write = 1'b1; d_wdata = 32'hCAFE0001; d_wstrb = 4'hF; d_activate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_activate !== 1'b1) $display("FAIL areset_busy: activate %0b want 1", mem_activate); else passed++;
        mem_done = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({mem_activate, d_done, mem_write} !== 3'b000) $display("FAIL areset_immediate: act/done/wr %b want 000", {mem_activate, d_done, mem_write}); else passed++;
        mem_done = 1'b0; d_activate = 1'b0; d_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i_addr = 32'h900; i_activate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (!mem_activate || mem_addr !== 32'h900) $display("FAIL areset_regrant: act %0b addr %h want 1 900", mem_activate, mem_addr); else passed++;
        mem_done = 1'b1; mem_rdata = 32'h13579BDF;
        #1;
        checks++; if (i_done !== 1'b1 || i_data !== 32'h13579BDF) $display("FAIL areset_done: done %0b data %h want 1 13579bdf", i_done, i_data); else passed++;
        @(posedge clk); #1;
        mem_done = 1'b0; i_activate = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: each port holds one
    // pending request until its done; the memory answers after 0..3 extra cycles.
    task automatic test_random();
        logic     busy, who_d, last_d, i_pend, d_pend;
        int       cnt;
        mem_req_t i_req, d_req, exp;
        logic [31:0] rdata;
        int       n_i, n_d;
        apply_reset();
        busy = 1'b0; who_d = 1'b0; last_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
        cnt = 0; n_i = 0; n_d = 0;
        i_req = '0; d_req = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_req.addr = $urandom; i_req.write = 1'b0; i_req.wdata = 32'd0; i_req.wstrb = 4'd0;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_req.addr = $urandom; d_req.write = 1'($urandom_range(0, 1));
                d_req.wdata = $urandom; d_req.wstrb = 4'($urandom_range(0, 15));
            end
            i_activate = i_pend; i_addr = i_req.addr;
            d_activate = d_pend; d_addr = d_req.addr; d_write = d_req.write;
            d_wdata = d_req.wdata; d_wstrb = d_req.wstrb;
            rdata = $urandom;
            mem_rdata = rdata;
            mem_done = busy ? (cnt == 0) : ($urandom_range(0, 7) == 0);
            @(negedge clk);
            checks++; if (mem_activate !== busy) $display("FAIL rnd_activate@%0d: got %0b want %0b", cyc, mem_activate, busy); else passed++;
            if (busy) begin
                exp = who_d ? d_req : i_req;
                checks++; if (mem_addr !== exp.addr || mem_write !== exp.write)
                    $display("FAIL rnd_req@%0d: addr %h wr %0b want %h %0b", cyc, mem_addr, mem_write, exp.addr, exp.write); else passed++;
                if (exp.write) begin
                    checks++; if (mem_wdata !== exp.wdata || mem_wstrb !== exp.wstrb)
                        $display("FAIL rnd_wdata@%0d: %h/%b want %h/%b", cyc, mem_wdata, mem_wstrb, exp.wdata, exp.wstrb); else passed++;
                end
            end
            checks++; if (i_done !== (busy && mem_done && !who_d) || d_done !== (busy && mem_done && who_d))
                $display("FAIL rnd_done@%0d: i/d %b%b want %b%b", cyc, i_done, d_done, busy && mem_done && !who_d, busy && mem_done && who_d); else passed++;
            if (busy && mem_done) begin
                checks++; if ((who_d ? d_data : i_data) !== rdata) $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, who_d ? d_data : i_data, rdata); else passed++;
            end
            @(posedge clk);
            if (busy) begin
                if (mem_done) begin
                    busy = 1'b0;
                    if (who_d) begin d_pend = 1'b0; n_d++; end
                    else begin i_pend = 1'b0; n_i++; end
                end else begin
                    cnt--;
                end
            end else if (i_pend || d_pend) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                who_d = d_pend && (!i_pend || !last_d);
`else
                who_d = d_pend;
`endif
                last_d = who_d;
                busy = 1'b1;
                cnt = $urandom_range(0, 3);
            end
            #1;
        end
        checks++; if (n_d == 0) $display("FAIL rnd_coverage: data completions %0d want >0", n_d); else passed++;
        clear_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
